chart_sequencer: RTL

- Reads the 4-lane note chart ROM one step at a time at a fixed tempo and turns each non-empty step into a spawn request for the falling-note renderer.
- Drives the ROM address and consumes its data, which has 1-cycle registered latency.
- Sits between the game-control FSM (start/pause) and the note-spawn logic (valid/ready).

---
 rtl/melody_pkg.sv | 14 +
 rtl/chart_sequencer_if.sv | 27 ++
 rtl/chart_sequencer_step_timer.sv | 22 ++
 rtl/chart_sequencer.sv | 88 ++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// melody_pkg: shared types and constants for the note chart sequencer
// Holds the lane width, default chart geometry, the sequencer state encoding
// and the lane bitmap constants (bit3 = lane 0).
package melody_pkg;
    localparam int LANE_W = 4;
    localparam int DEF_ADDR_W = 13;
    localparam int DEF_SONG_LEN = 274;
    localparam int DEF_TICKS_PER_STEP = 12500000;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, TICK, DONE} seq_state_t;
    localparam logic [LANE_W-1:0] LANE0 = 4'b1000;
    localparam logic [LANE_W-1:0] LANE1 = 4'b0100;
    localparam logic [LANE_W-1:0] LANE2 = 4'b0010;
    localparam logic [LANE_W-1:0] LANE3 = 4'b0001;
endpackage

// File: rtl/chart_sequencer_if.sv
// chart_sequencer_if: control, chart ROM and spawn handshake bundle
// master (sequencer): in start, pause, rom_data, spawn_ready;
//                     out rom_addr, spawn_valid, spawn_lanes, step_idx, busy, done, overrun
// slave (environment): the mirror image.
interface chart_sequencer_if import melody_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              start;
    logic              pause;
    logic [ADDR_W-1:0] rom_addr;
    logic [LANE_W-1:0] rom_data;
    logic              spawn_valid;
    logic [LANE_W-1:0] spawn_lanes;
    logic              spawn_ready;
    logic [ADDR_W-1:0] step_idx;
    logic              busy;
    logic              done;
    logic              overrun;
    modport master (
        input  start, pause, rom_data, spawn_ready,
        output rom_addr, spawn_valid, spawn_lanes, step_idx, busy, done, overrun
    );
    modport slave (
        output start, pause, rom_data, spawn_ready,
        input  rom_addr, spawn_valid, spawn_lanes, step_idx, busy, done, overrun
    );
endinterface

// File: rtl/chart_sequencer_step_timer.sv
// step_timer: per-step tick counter with enable, clear and terminal count
// Ports: clk, reset (async, active-high), en (count), clr (return to 0, wins over en),
//        tc (tick has reached TICKS-3, the last TICK cycle of a step).
module step_timer #(
    parameter int TICKS = 12500000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tc
);
    localparam int TW = $clog2(TICKS);
    logic [TW-1:0] tick;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tick <= '0;
        else if (clr) tick <= '0;
        else if (en) tick <= tick + 1'b1;
    end
    // FETCH and WAIT take two cycles of each step, so TICK spans TICKS-2 counts
    assign tc = tick == TW'(TICKS - 3);
endmodule

// File: rtl/chart_sequencer.sv
// chart_sequencer: steps through the note chart ROM at a fixed tempo and emits spawn requests
// Ports: clk, reset (async, active-high), bus (chart_sequencer_if.master: start/pause
//        control, ROM address/data, spawn valid/ready/lanes, step_idx, busy, done, overrun).
// Build option CHART_LOOP_EN: wrap to step 0 after the last step instead of entering DONE;
// done then pulses for one cycle at each wrap.
module chart_sequencer import melody_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int SONG_LEN = DEF_SONG_LEN,
    parameter int TICKS_PER_STEP = DEF_TICKS_PER_STEP
) (
    input logic clk,
    input logic reset,
    chart_sequencer_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
    seq_state_t state, state_d;
    logic go, adv, tc, last;
    assign last = bus.rom_addr == LAST_ADDR;
    step_timer #(.TICKS(TICKS_PER_STEP)) u_timer (
        .clk(clk),
        .reset(reset),
        .en(state == TICK && !bus.pause),
        .clr(go || adv),
        .tc(tc)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_d;
    end
    always_comb begin
        state_d = state;
        go = 1'b0;
        adv = 1'b0;
        case (state)
            IDLE, DONE: begin
                go = bus.start;
                state_d = bus.start ? FETCH : state;
            end
            FETCH: state_d = WAIT;
            WAIT: state_d = TICK;
            TICK: begin
                adv = !bus.pause && tc;
`ifdef CHART_LOOP_EN
                state_d = adv ? FETCH : TICK;
`else
                state_d = adv ? (last ? DONE : FETCH) : TICK;
`endif
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.busy = state inside {FETCH, WAIT, TICK};
`ifdef CHART_LOOP_EN
    logic wrap_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wrap_q <= 1'b0;
        else wrap_q <= adv && last;
    end
    assign bus.done = wrap_q;
`else
    assign bus.done = state == DONE;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rom_addr <= '0;
            bus.step_idx <= '0;
            bus.spawn_valid <= 1'b0;
            bus.spawn_lanes <= '0;
            bus.overrun <= 1'b0;
        end else begin
            if (go) begin
                bus.rom_addr <= '0;
                bus.overrun <= 1'b0;
`ifdef CHART_LOOP_EN
            end else if (adv) bus.rom_addr <= last ? '0 : bus.rom_addr + 1'b1;
`else
            end else if (adv && !last) bus.rom_addr <= bus.rom_addr + 1'b1;
`endif
            if (state == WAIT) bus.step_idx <= bus.rom_addr;
            // A new non-empty step replaces any pending request; losing an unaccepted one is an overrun
            if (state == WAIT && bus.rom_data != '0) begin
                bus.spawn_lanes <= bus.rom_data;
                bus.spawn_valid <= 1'b1;
                if (bus.spawn_valid && !bus.spawn_ready) bus.overrun <= 1'b1;
            end else if (bus.spawn_valid && bus.spawn_ready) bus.spawn_valid <= 1'b0;
        end
    end
endmodule
